multi_pass_exp_sequencer: RTL and testbench

Top-level sequencer for state-variable expression evaluation. It fetches the initial state values once, then runs NUM_PASSES passes. Each pass steps through three sub-blocks: angle combination, angle normalisation and term accumulation. While a sub-block is active, the sequencer routes the shared FP units (NUM_ADDERS adders, mult, exponent, div) and the angle-value memory port to it, and writes each pass result back to state-variable memory.

---
 rtl/multi_pass_exp_sequencer_if.sv | 125 ++++++++++++
 rtl/multi_pass_exp_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_multi_pass_exp_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_pass_exp_sequencer_if.sv
// ---------------------------------------------------------------------------
// multi_pass_exp_sequencer_if
//
// Purpose: groups every bus-level signal of the multi-pass expression
// sequencer. This covers the start/status handshake, the state-variable
// memory ports, the phase handshakes, the shared FP unit operands and the
// angle-memory port.
//
// Modports:
//   master : the sequencer. It consumes the requests from the sub-blocks and
//            drives the shared FP units, the memories and the status.
//   slave  : the surrounding environment (sub-blocks, memories, FP units).
//
// Signal summary:
//   start / busy / done / error     control handshake and sticky timeout flag
//   sv_rd_addr / sv_rd_data         state-var read port (1-cycle latency)
//   sv_wr_addr / sv_wr_data / sv_we state-var write port
//   init_val_flat                   captured initial values, word k at [k*DW +: DW]
//   pass_idx                        current evaluation pass
//   {comb,norm,term}_start/_done    phase handshakes
//   comb_*, norm_*, term_*          sub-block requests for the shared resources
//   add_*, mult_*, exp_*, div_*     muxed shared FP unit operands/starts
//   angle_*                         muxed angle-memory port
// ---------------------------------------------------------------------------
interface multi_pass_exp_sequencer_if #(
    parameter int NUM_INIT_VAL   = 6,
    parameter int NUM_PASSES     = 3,
    parameter int NUM_ADDERS     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_ANGLE_COMB = 21,
    parameter int SV_AW          = $clog2(NUM_INIT_VAL + NUM_PASSES),
    parameter int PASS_W         = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1,
    parameter int ANGLE_AW       = (NUM_ANGLE_COMB > 1) ? $clog2(NUM_ANGLE_COMB) : 1
);
    logic                               start;
    logic                               busy;
    logic                               done;
    logic                               error;

    logic [SV_AW-1:0]                   sv_rd_addr;
    logic [DATA_WIDTH-1:0]              sv_rd_data;
    logic [SV_AW-1:0]                   sv_wr_addr;
    logic [DATA_WIDTH-1:0]              sv_wr_data;
    logic                               sv_we;

    logic [NUM_INIT_VAL*DATA_WIDTH-1:0] init_val_flat;
    logic [PASS_W-1:0]                  pass_idx;

    logic                               comb_start;
    logic                               norm_start;
    logic                               term_start;
    logic                               comb_done;
    logic                               norm_done;
    logic                               term_done;
    logic [DATA_WIDTH-1:0]              term_value;

    logic [NUM_ADDERS*DATA_WIDTH-1:0]   comb_add_a;
    logic [NUM_ADDERS*DATA_WIDTH-1:0]   comb_add_b;
    logic [NUM_ADDERS-1:0]              comb_add_start;
    logic [DATA_WIDTH-1:0]              norm_add_a;
    logic [DATA_WIDTH-1:0]              norm_add_b;
    logic                               norm_add_start;
    logic [DATA_WIDTH-1:0]              term_op_a;
    logic [DATA_WIDTH-1:0]              term_op_b;
    logic                               term_add_start;
    logic                               term_mult_start;
    logic                               term_exp_start;
    logic                               term_div_start;

    logic                               comb_mem_we;
    logic [ANGLE_AW-1:0]                comb_mem_waddr;
    logic [DATA_WIDTH-1:0]              comb_mem_wdata;
    logic                               norm_mem_we;
    logic [ANGLE_AW-1:0]                norm_mem_waddr;
    logic [ANGLE_AW-1:0]                norm_mem_raddr;
    logic [DATA_WIDTH-1:0]              norm_mem_wdata;

    logic [NUM_ADDERS*DATA_WIDTH-1:0]   add_a;
    logic [NUM_ADDERS*DATA_WIDTH-1:0]   add_b;
    logic [NUM_ADDERS-1:0]              add_start;
    logic [DATA_WIDTH-1:0]              mult_a;
    logic [DATA_WIDTH-1:0]              mult_b;
    logic                               mult_start;
    logic [DATA_WIDTH-1:0]              exp_a;
    logic [DATA_WIDTH-1:0]              exp_b;
    logic                               exp_start;
    logic [DATA_WIDTH-1:0]              div_dividend;
    logic [DATA_WIDTH-1:0]              div_divisor;
    logic                               div_start;

    logic                               angle_we;
    logic [ANGLE_AW-1:0]                angle_waddr;
    logic [ANGLE_AW-1:0]                angle_raddr;
    logic [DATA_WIDTH-1:0]              angle_wdata;

    modport master (
        input  start, sv_rd_data, comb_done, norm_done, term_done, term_value,
               comb_add_a, comb_add_b, comb_add_start,
               norm_add_a, norm_add_b, norm_add_start,
               term_op_a, term_op_b, term_add_start, term_mult_start,
               term_exp_start, term_div_start,
               comb_mem_we, comb_mem_waddr, comb_mem_wdata,
               norm_mem_we, norm_mem_waddr, norm_mem_raddr, norm_mem_wdata,
        output busy, done, error, sv_rd_addr, sv_wr_addr, sv_wr_data, sv_we,
               init_val_flat, pass_idx, comb_start, norm_start, term_start,
               add_a, add_b, add_start, mult_a, mult_b, mult_start,
               exp_a, exp_b, exp_start, div_dividend, div_divisor, div_start,
               angle_we, angle_waddr, angle_raddr, angle_wdata
    );

    modport slave (
        output start, sv_rd_data, comb_done, norm_done, term_done, term_value,
               comb_add_a, comb_add_b, comb_add_start,
               norm_add_a, norm_add_b, norm_add_start,
               term_op_a, term_op_b, term_add_start, term_mult_start,
               term_exp_start, term_div_start,
               comb_mem_we, comb_mem_waddr, comb_mem_wdata,
               norm_mem_we, norm_mem_waddr, norm_mem_raddr, norm_mem_wdata,
        input  busy, done, error, sv_rd_addr, sv_wr_addr, sv_wr_data, sv_we,
               init_val_flat, pass_idx, comb_start, norm_start, term_start,
               add_a, add_b, add_start, mult_a, mult_b, mult_start,
               exp_a, exp_b, exp_start, div_dividend, div_divisor, div_start,
               angle_we, angle_waddr, angle_raddr, angle_wdata
    );
endinterface

// File: rtl/multi_pass_exp_sequencer.sv
// ---------------------------------------------------------------------------
// multi_pass_exp_sequencer
//
// Purpose: top-level sequencer for state-variable expression evaluation.
// On start it fetches NUM_INIT_VAL initial values from state-variable memory.
// It then runs NUM_PASSES passes, each consisting of angle combination, angle
// normalisation and term accumulation. While a sub-block is active, the
// shared FP units and the angle-memory port are routed to it. The pass result
// (term_value) is written back to state-var address NUM_INIT_VAL + pass.
//
// Ports:
//   clock  : single clock
//   reset  : asynchronous, active-low reset
//   bus    : multi_pass_exp_sequencer_if.master (handshakes, memories, FP units)
//
// Optional feature (macro PHASE_TIMEOUT_EN):
//   If the macro is defined, each WAIT phase has a watchdog of TIMEOUT_CYCLES.
//   On expiry the sticky error flag is set, the write-back for that pass is
//   skipped and the run finishes with a done pulse.
//   If the macro is undefined, error is tied 0 and the WAIT states wait
//   indefinitely.
// ---------------------------------------------------------------------------
module multi_pass_exp_sequencer #(
    parameter int NUM_INIT_VAL   = 6,
    parameter int NUM_PASSES     = 3,
    parameter int NUM_ADDERS     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_ANGLE_COMB = 21,
    parameter int SV_AW          = $clog2(NUM_INIT_VAL + NUM_PASSES),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clock,
    input  logic                       reset,
    multi_pass_exp_sequencer_if.master bus
);

    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int FC_W   = $clog2(NUM_INIT_VAL + 1);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        COMB_START,
        COMB_WAIT,
        NORM_START,
        NORM_WAIT,
        TERM_START,
        TERM_WAIT,
        WRITE_BACK,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [FC_W-1:0]       fetchCnt_q, fetchCnt_d;
    logic [PASS_W-1:0]     passIdx_q, passIdx_d;
    logic [DATA_WIDTH-1:0] termValue_q, termValue_d;
    logic [DATA_WIDTH-1:0] initVal_q [NUM_INIT_VAL];
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  svWe_q, svWe_d;
    logic                  combStart_q, combStart_d;
    logic                  normStart_q, normStart_d;
    logic                  termStart_q, termStart_d;
    logic                  inWait;
    logic                  timeoutHit;
    logic                  errorSet;
    logic                  errorClr;

    assign inWait = (state_q == COMB_WAIT) || (state_q == NORM_WAIT) || (state_q == TERM_WAIT);

    // Next-state logic. A phase done always takes priority over a watchdog
    // expiry in the same cycle. The registered status/strobe outputs are
    // derived from the next state, so each one is high exactly while the FSM
    // sits in the matching state.
    always_comb begin
        state_d     = state_q;
        fetchCnt_d  = fetchCnt_q;
        passIdx_d   = passIdx_q;
        termValue_d = termValue_q;
        errorSet    = 1'b0;
        errorClr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = FETCH;
                    fetchCnt_d = '0;
                    errorClr   = 1'b1;
                end
            end
            FETCH: begin
                if (fetchCnt_q == FC_W'(NUM_INIT_VAL)) begin
                    state_d = COMB_START;
                end else begin
                    fetchCnt_d = fetchCnt_q + 1'b1;
                end
            end
            COMB_START: state_d = COMB_WAIT;
            COMB_WAIT: begin
                if (bus.comb_done) begin
                    state_d = NORM_START;
                end else if (timeoutHit) begin
                    state_d  = FINISH;
                    errorSet = 1'b1;
                end
            end
            NORM_START: state_d = NORM_WAIT;
            NORM_WAIT: begin
                if (bus.norm_done) begin
                    state_d = TERM_START;
                end else if (timeoutHit) begin
                    state_d  = FINISH;
                    errorSet = 1'b1;
                end
            end
            TERM_START: state_d = TERM_WAIT;
            TERM_WAIT: begin
                if (bus.term_done) begin
                    state_d     = WRITE_BACK;
                    termValue_d = bus.term_value;
                end else if (timeoutHit) begin
                    state_d  = FINISH;
                    errorSet = 1'b1;
                end
            end
            WRITE_BACK: begin
                if (passIdx_q < PASS_W'(NUM_PASSES - 1)) begin
                    passIdx_d = passIdx_q + 1'b1;
                    state_d   = COMB_START;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                passIdx_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE) && (state_d != FINISH);
        done_d      = (state_d == FINISH);
        svWe_d      = (state_d == WRITE_BACK);
        combStart_d = (state_d == COMB_START);
        normStart_d = (state_d == NORM_START);
        termStart_d = (state_d == TERM_START);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            fetchCnt_q  <= '0;
            passIdx_q   <= '0;
            termValue_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            svWe_q      <= 1'b0;
            combStart_q <= 1'b0;
            normStart_q <= 1'b0;
            termStart_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetchCnt_q  <= fetchCnt_d;
            passIdx_q   <= passIdx_d;
            termValue_q <= termValue_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            svWe_q      <= svWe_d;
            combStart_q <= combStart_d;
            normStart_q <= normStart_d;
            termStart_q <= termStart_d;
        end
    end

    // Initial-value capture: the read port has one cycle of latency, so
    // during FETCH cycle c the data of address c-1 is on sv_rd_data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_INIT_VAL; k++) begin
                initVal_q[k] <= '0;
            end
        end else if (state_q == FETCH) begin
            for (int k = 0; k < NUM_INIT_VAL; k++) begin
                if (fetchCnt_q == FC_W'(k + 1)) begin
                    initVal_q[k] <= bus.sv_rd_data;
                end
            end
        end
    end

    always_comb begin
        bus.init_val_flat = '0;
        for (int k = 0; k < NUM_INIT_VAL; k++) begin
            bus.init_val_flat[k*DATA_WIDTH +: DATA_WIDTH] = initVal_q[k];
        end
    end

    assign bus.sv_rd_addr = ((state_q == FETCH) && (fetchCnt_q < FC_W'(NUM_INIT_VAL)))
                            ? SV_AW'(fetchCnt_q) : '0;
    assign bus.sv_wr_addr = SV_AW'(NUM_INIT_VAL) + SV_AW'(passIdx_q);
    assign bus.sv_wr_data = termValue_q;
    assign bus.sv_we      = svWe_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass_idx   = passIdx_q;
    assign bus.comb_start = combStart_q;
    assign bus.norm_start = normStart_q;
    assign bus.term_start = termStart_q;

    // Shared-resource routing. This is purely a function of the current
    // state. Everything defaults to zero so that idle FP units and the angle
    // memory never see stray requests.
    always_comb begin
        bus.add_a        = '0;
        bus.add_b        = '0;
        bus.add_start    = '0;
        bus.mult_a       = '0;
        bus.mult_b       = '0;
        bus.mult_start   = 1'b0;
        bus.exp_a        = '0;
        bus.exp_b        = '0;
        bus.exp_start    = 1'b0;
        bus.div_dividend = '0;
        bus.div_divisor  = '0;
        bus.div_start    = 1'b0;
        bus.angle_we     = 1'b0;
        bus.angle_waddr  = '0;
        bus.angle_raddr  = '0;
        bus.angle_wdata  = '0;

        case (state_q)
            COMB_WAIT: begin
                bus.add_a       = bus.comb_add_a;
                bus.add_b       = bus.comb_add_b;
                bus.add_start   = bus.comb_add_start;
                bus.angle_we    = bus.comb_mem_we;
                bus.angle_waddr = bus.comb_mem_waddr;
                bus.angle_wdata = bus.comb_mem_wdata;
            end
            NORM_WAIT: begin
                bus.add_a[DATA_WIDTH-1:0] = bus.norm_add_a;
                bus.add_b[DATA_WIDTH-1:0] = bus.norm_add_b;
                bus.add_start[0]          = bus.norm_add_start;
                bus.angle_we              = bus.norm_mem_we;
                bus.angle_waddr           = bus.norm_mem_waddr;
                bus.angle_raddr           = bus.norm_mem_raddr;
                bus.angle_wdata           = bus.norm_mem_wdata;
            end
            TERM_WAIT: begin
                bus.add_a[DATA_WIDTH-1:0] = bus.term_op_a;
                bus.add_b[DATA_WIDTH-1:0] = bus.term_op_b;
                bus.add_start[0]          = bus.term_add_start;
                bus.mult_a                = bus.term_op_a;
                bus.mult_b                = bus.term_op_b;
                bus.mult_start            = bus.term_mult_start;
                bus.exp_a                 = bus.term_op_a;
                bus.exp_b                 = bus.term_op_b;
                bus.exp_start             = bus.term_exp_start;
                bus.div_dividend          = bus.term_op_a;
                bus.div_divisor           = bus.term_op_b;
                bus.div_start             = bus.term_div_start;
            end
            default: ;
        endcase
    end

    // The angle depth and timeout limit are configuration-only in some builds.
    logic unusedCfg;
    assign unusedCfg = NUM_ANGLE_COMB[0] ^ TIMEOUT_CYCLES[0];

`ifdef PHASE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] toCnt_q, toCnt_d;
    logic            error_q, error_d;

    // The watchdog restarts on entry to every WAIT state and counts WAIT
    // cycles. It expires on the TIMEOUT_CYCLES-th WAIT cycle without done.
    always_comb begin
        toCnt_d = '0;
        if (inWait && (state_d == state_q)) begin
            toCnt_d = toCnt_q + 1'b1;
        end
        error_d = error_q;
        if (errorClr) begin
            error_d = 1'b0;
        end else if (errorSet) begin
            error_d = 1'b1;
        end
    end

    assign timeoutHit = inWait && (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            toCnt_q <= '0;
            error_q <= 1'b0;
        end else begin
            toCnt_q <= toCnt_d;
            error_q <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    logic unusedErrCtl;
    assign timeoutHit   = 1'b0;
    assign bus.error    = 1'b0;
    assign unusedErrCtl = errorSet | errorClr | inWait;
`endif

endmodule

// File: tb/tb_multi_pass_exp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multi_pass_exp_sequencer
//
// Purpose: self-checking bench for multi_pass_exp_sequencer. The bench plays
// the state-variable memory and the three phase sub-blocks. It drives random
// sub-block requests and compares the routed shared-resource outputs and
// the write-backs against a behavioural model of the sequence. The model
// tracks which phase should be active, which value each pass must write,
// and how long fetch and timeout take.
// Runs the PHASE_TIMEOUT_EN scenario when that macro is defined.
// ---------------------------------------------------------------------------
module tb_multi_pass_exp_sequencer;

    localparam int NIV = 6;
    localparam int NP  = 3;
    localparam int NA  = 2;
    localparam int DW  = 32;
    localparam int NAC = 21;
    localparam int TO  = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checkCount = 0;
    int   failCount  = 0;
    int   weCount    = 0;
    int   doneCount  = 0;

    logic [DW-1:0]       svMem [16];
    logic [NIV*DW-1:0]   expFlat;

    always #5 clock = ~clock;

    multi_pass_exp_sequencer_if #(
        .NUM_INIT_VAL(NIV), .NUM_PASSES(NP), .NUM_ADDERS(NA),
        .DATA_WIDTH(DW), .NUM_ANGLE_COMB(NAC)
    ) bus ();

    multi_pass_exp_sequencer #(
        .NUM_INIT_VAL(NIV), .NUM_PASSES(NP), .NUM_ADDERS(NA),
        .DATA_WIDTH(DW), .NUM_ANGLE_COMB(NAC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.master)
    );

    // State-variable memory model with a one-cycle read latency, plus
    // counters for write strobes and done pulses.
    always @(posedge clock) begin
        bus.sv_rd_data <= svMem[bus.sv_rd_addr];
        if (bus.sv_we) weCount <= weCount + 1;
        if (bus.done) doneCount <= doneCount + 1;
    end

    // Hard time limit so that a hung design cannot stall the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount + 1);
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [255:0] actual,
                               input logic [255:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Randomise every sub-block request so that the routing checks see
    // different values in each cycle.
    task automatic applyStimulus();
        bus.comb_add_a      = {$urandom, $urandom};
        bus.comb_add_b      = {$urandom, $urandom};
        bus.comb_add_start  = 2'($urandom_range(0, 3));
        bus.norm_add_a      = $urandom;
        bus.norm_add_b      = $urandom;
        bus.norm_add_start  = 1'($urandom_range(0, 1));
        bus.term_op_a       = $urandom;
        bus.term_op_b       = $urandom;
        bus.term_add_start  = 1'($urandom_range(0, 1));
        bus.term_mult_start = 1'($urandom_range(0, 1));
        bus.term_exp_start  = 1'($urandom_range(0, 1));
        bus.term_div_start  = 1'($urandom_range(0, 1));
        bus.comb_mem_we     = 1'($urandom_range(0, 1));
        bus.comb_mem_waddr  = 5'($urandom_range(0, NAC - 1));
        bus.comb_mem_wdata  = $urandom;
        bus.norm_mem_we     = 1'($urandom_range(0, 1));
        bus.norm_mem_waddr  = 5'($urandom_range(0, NAC - 1));
        bus.norm_mem_raddr  = 5'($urandom_range(0, NAC - 1));
        bus.norm_mem_wdata  = $urandom;
    endtask

    // Expected shared-resource outputs. ph: 0=comb, 1=norm, 2=term, else
    // no owner.
    task automatic checkRouting(input int ph, input string where);
        logic [NA*DW-1:0] eAddA, eAddB;
        logic [NA-1:0]    eAddStart;
        logic [DW-1:0]    eMa, eMb, eEa, eEb, eDa, eDb, eWdata;
        logic             eMs, eEs, eDs, eWe;
        logic [4:0]       eWaddr, eRaddr;
        eAddA = '0; eAddB = '0; eAddStart = '0;
        eMa = '0; eMb = '0; eEa = '0; eEb = '0; eDa = '0; eDb = '0; eWdata = '0;
        eMs = 1'b0; eEs = 1'b0; eDs = 1'b0; eWe = 1'b0; eWaddr = '0; eRaddr = '0;
        if (ph == 0) begin
            eAddA = bus.comb_add_a; eAddB = bus.comb_add_b; eAddStart = bus.comb_add_start;
            eWe = bus.comb_mem_we; eWaddr = bus.comb_mem_waddr; eWdata = bus.comb_mem_wdata;
        end else if (ph == 1) begin
            eAddA = {{DW{1'b0}}, bus.norm_add_a};
            eAddB = {{DW{1'b0}}, bus.norm_add_b};
            eAddStart = {1'b0, bus.norm_add_start};
            eWe = bus.norm_mem_we; eWaddr = bus.norm_mem_waddr;
            eRaddr = bus.norm_mem_raddr; eWdata = bus.norm_mem_wdata;
        end else if (ph == 2) begin
            eAddA = {{DW{1'b0}}, bus.term_op_a};
            eAddB = {{DW{1'b0}}, bus.term_op_b};
            eAddStart = {1'b0, bus.term_add_start};
            eMa = bus.term_op_a; eMb = bus.term_op_b; eMs = bus.term_mult_start;
            eEa = bus.term_op_a; eEb = bus.term_op_b; eEs = bus.term_exp_start;
            eDa = bus.term_op_a; eDb = bus.term_op_b; eDs = bus.term_div_start;
        end
        checkOutput({where, ".add_a"}, bus.add_a, eAddA);
        checkOutput({where, ".add_b"}, bus.add_b, eAddB);
        checkOutput({where, ".add_start"}, bus.add_start, eAddStart);
        checkOutput({where, ".mult_a"}, bus.mult_a, eMa);
        checkOutput({where, ".mult_b"}, bus.mult_b, eMb);
        checkOutput({where, ".mult_start"}, bus.mult_start, eMs);
        checkOutput({where, ".exp_a"}, bus.exp_a, eEa);
        checkOutput({where, ".exp_b"}, bus.exp_b, eEb);
        checkOutput({where, ".exp_start"}, bus.exp_start, eEs);
        checkOutput({where, ".div_dividend"}, bus.div_dividend, eDa);
        checkOutput({where, ".div_divisor"}, bus.div_divisor, eDb);
        checkOutput({where, ".div_start"}, bus.div_start, eDs);
        checkOutput({where, ".angle_we"}, bus.angle_we, eWe);
        checkOutput({where, ".angle_waddr"}, bus.angle_waddr, eWaddr);
        checkOutput({where, ".angle_raddr"}, bus.angle_raddr, eRaddr);
        checkOutput({where, ".angle_wdata"}, bus.angle_wdata, eWdata);
    endtask

    task automatic checkIdle(input string where);
        checkOutput({where, ".busy"}, bus.busy, 0);
        checkOutput({where, ".done"}, bus.done, 0);
        checkOutput({where, ".sv_we"}, bus.sv_we, 0);
        checkOutput({where, ".starts"}, {bus.comb_start, bus.norm_start, bus.term_start}, 0);
        checkOutput({where, ".pass_idx"}, bus.pass_idx, 0);
    endtask

    // One complete run. resetAtPass >= 0 pulls reset during that pass's
    // TERM_WAIT (with term_done raised at the same time). timeoutNorm holds
    // norm_done low in pass 0. seqPattern uses the fixed memory/term values.
    task automatic runOnce(input int resetAtPass, input bit timeoutNorm, input bit seqPattern);
        int            cnt;
        int            lat;
        int            we0;
        int            done0;
        logic [DW-1:0] expTerm;
        string         phName;
        for (int k = 0; k < 16; k++) begin
            svMem[k] = (seqPattern && k < NIV) ? (32'h3F80_0000 + k) : $urandom;
        end
        for (int k = 0; k < NIV; k++) expFlat[k*DW +: DW] = svMem[k];
        we0   = weCount;
        done0 = doneCount;

        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        checkOutput("busyAfterStart", bus.busy, 1);
        checkOutput("errorClearedOnStart", bus.error, 0);
        cnt = 1;
        while (!bus.comb_start && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        checkOutput("fetchCycles", cnt - 1, NIV + 1);
        if (!bus.comb_start) return;
        checkOutput("initValFlat", bus.init_val_flat, expFlat);

        for (int p = 0; p < NP; p++) begin
            expTerm = seqPattern ? (32'h4000_0000 + p) : $urandom;
            for (int ph = 0; ph < 3; ph++) begin
                phName = (ph == 0) ? "comb" : (ph == 1) ? "norm" : "term";
                // Exactly one phase start, in the cycle right after the
                // previous phase completed.
                checkOutput({phName, ".startPulse"},
                            {bus.comb_start, bus.norm_start, bus.term_start},
                            3'b100 >> ph);
                checkOutput({phName, ".pass_idx"}, bus.pass_idx, p);
                checkOutput({phName, ".svWeLow"}, bus.sv_we, 0);
                applyStimulus();
                #1;
                checkRouting(-1, {phName, "Start"});
                @(negedge clock);
                checkOutput({phName, ".startDropped"},
                            {bus.comb_start, bus.norm_start, bus.term_start}, 0);

                if (resetAtPass == p && ph == 2) begin
                    bus.term_done  = 1'b1;
                    bus.term_value = expTerm;
                    reset = 1'b0;
                    @(negedge clock);
                    reset = 1'b1;
                    bus.term_done = 1'b0;
                    #1;
                    checkIdle("afterReset");
                    checkOutput("afterReset.initClr", bus.init_val_flat, 0);
                    checkRouting(-1, "afterReset");
                    @(negedge clock);
                    checkIdle("afterResetHold");
                    checkOutput("afterReset.noWrite", weCount, we0 + p);
                    return;
                end

                if (timeoutNorm && ph == 1) begin
                    cnt = 1;
                    while (!bus.done && cnt < 100) begin
                        applyStimulus();
                        #1;
                        checkRouting(1, "normTimeout");
                        @(negedge clock);
                        cnt++;
                    end
                    checkOutput("timeoutWaitCycles", cnt - 1, TO);
                    checkOutput("timeoutError", bus.error, 1);
                    checkOutput("timeoutBusy", bus.busy, 0);
                    checkOutput("timeoutNoWrite", weCount, we0);
                    @(negedge clock);
                    checkIdle("afterTimeout");
                    checkOutput("timeoutErrorSticky", bus.error, 1);
                    checkOutput("timeoutDonePulses", doneCount, done0 + 1);
                    return;
                end

                lat = seqPattern ? 5 : $urandom_range(1, 6);
                for (int w = 1; w <= lat; w++) begin
                    applyStimulus();
                    if (ph == 2 && w == 1) bus.start = 1'b1;
                    #1;
                    checkRouting(ph, {phName, "Wait"});
                    if (w == lat) begin
                        if (ph == 0) bus.comb_done = 1'b1;
                        if (ph == 1) bus.norm_done = 1'b1;
                        if (ph == 2) begin
                            bus.term_done  = 1'b1;
                            bus.term_value = expTerm;
                        end
                    end
                    @(negedge clock);
                    bus.start      = 1'b0;
                    bus.comb_done  = 1'b0;
                    bus.norm_done  = 1'b0;
                    bus.term_done  = 1'b0;
                    bus.term_value = $urandom;
                end
            end

            checkOutput("wb.sv_we", bus.sv_we, 1);
            checkOutput("wb.sv_wr_addr", bus.sv_wr_addr, NIV + p);
            checkOutput("wb.sv_wr_data", bus.sv_wr_data, expTerm);
            checkOutput("wb.busy", bus.busy, 1);
            @(negedge clock);
        end

        checkOutput("finish.done", bus.done, 1);
        checkOutput("finish.busy", bus.busy, 0);
        checkOutput("finish.sv_we", bus.sv_we, 0);
        @(negedge clock);
        checkIdle("afterFinish");
        checkOutput("writeCount", weCount, we0 + NP);
        checkOutput("donePulses", doneCount, done0 + 1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.comb_done = 1'b0;
        bus.norm_done = 1'b0;
        bus.term_done = 1'b0;
        bus.term_value = '0;
        applyStimulus();
        for (int k = 0; k < 16; k++) svMem[k] = '0;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkIdle("reset");
        checkOutput("reset.error", bus.error, 0);
        checkOutput("reset.initVals", bus.init_val_flat, 0);
        checkRouting(-1, "reset");
        reset = 1'b1;
        @(negedge clock);

        runOnce(-1, 1'b0, 1'b1);
        runOnce(1, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) runOnce(-1, 1'b0, 1'b0);
`ifdef PHASE_TIMEOUT_EN
        runOnce(-1, 1'b1, 1'b0);
        runOnce(-1, 1'b0, 1'b0);
        checkOutput("errorAfterRecovery", bus.error, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
